// File: rtl/fpas_issue_seq.sv
// Operand-issue sequencer for the non-pipelined FP add/sub unit: buffers requests,
// issues one at a time, waits out the adder latency and offers the result on valid/ready.
module fpas_issue_seq #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LATENCY = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_opcode,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        fpas_rst,
  output logic        fpas_start,
  output logic        fpas_opcode,
  output logic [31:0] fpas_ieee1,
  output logic [31:0] fpas_ieee2,
  input  logic [31:0] fpas_result
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(LATENCY + 1);
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
  localparam logic [CW-1:0] LAT_CNT  = LATENCY[CW-1:0];

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [64:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [1:0]    state;
  logic [CW-1:0] lat_cnt;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;

  // Issue only when the output slot is free or drains on this same edge,
  // so a captured result can never overwrite one still waiting.
  always_comb begin
    full     = (count == FULL_CNT);
    empty    = (count == '0);
    in_ready = !full;
    push     = in_valid && !full;
    pop      = (state == S_IDLE) && !empty && !fpas_rst && (!out_valid || out_ready);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_opcode, in_a, in_b};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      lat_cnt     <= '0;
      fpas_rst    <= 1'b1;
      fpas_start  <= 1'b0;
      fpas_opcode <= 1'b0;
      fpas_ieee1  <= '0;
      fpas_ieee2  <= '0;
      out_valid   <= 1'b0;
      out_result  <= '0;
    end else begin
      fpas_rst <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            {fpas_opcode, fpas_ieee1, fpas_ieee2} <= mem[rd_ptr];
            fpas_start <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          fpas_start <= 1'b0;
          lat_cnt    <= CW'(1);
          state      <= S_WAIT;
        end
        S_WAIT: begin
          if (lat_cnt == LAT_CNT) begin
            out_result <= fpas_result;
            out_valid  <= 1'b1;
            lat_cnt    <= '0;
            state      <= S_IDLE;
          end else begin
            lat_cnt <= lat_cnt + CW'(1);
          end
        end
        default: begin
          fpas_start <= 1'b0;
          lat_cnt    <= '0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule
